// File: rtl/csr_trap_ctrl_pkg.sv
// rtl/csr_trap_ctrl_pkg.sv - shared types and constants for the machine-mode trap sequencer
package csr_trap_ctrl_pkg;

   // Sequencer states: trap path writes mepc, mcause, mstatus then jumps; mret path writes mstatus then jumps
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_T_EPC    = 3'd1,
      ST_T_CAUSE  = 3'd2,
      ST_T_STATUS = 3'd3,
      ST_T_JUMP   = 3'd4,
      ST_R_STATUS = 3'd5,
      ST_R_JUMP   = 3'd6
   } state_t;

   // CSR addresses of the registers this block touches
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   // mstatus field positions
   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam logic [1:0] MPP_MACHINE = 2'b11;

   // mcause values
   localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;
   localparam logic [63:0] CAUSE_ECALL_M = 64'd11;

   // mtvec mode field encodings; 2'b1x are reserved and handled as direct
   localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
   localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/csr_trap_target.sv
// rtl/csr_trap_target.sv - trap handler address from mtvec base/mode and cause
module csr_trap_target #(
   parameter int XLEN      = 64,
   parameter bit VECTOR_EN = 1'b1
) (
   input  logic [XLEN-1:0] mtvec,
   input  logic [5:0]      cause,
   input  logic            is_irq,
   output logic [XLEN-1:0] redirect_pc
);
   import csr_trap_ctrl_pkg::*;

   logic [XLEN-1:0] base;
   logic [XLEN-1:0] offset;

   // Vectored mode offsets interrupts by 4*cause; exceptions and every other mode land on the base
   always_comb begin
      base   = {mtvec[XLEN-1:2], 2'b00};
      offset = {{(XLEN-8){1'b0}}, cause, 2'b00};
      if (VECTOR_EN && is_irq && (mtvec[1:0] == MTVEC_VECTORED)) begin
         redirect_pc = base + offset;
      end else begin
         redirect_pc = base;
      end
   end

endmodule

// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - machine-mode trap/mret sequencer driving the dedicated CSR write ports
module csr_trap_ctrl #(
   parameter int XLEN      = 64,
   parameter bit VECTOR_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            trap_req,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            irq_timer,
   input  logic            irq_en,
   input  logic [XLEN-1:0] irq_pc,
   input  logic            mret_req,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic [XLEN-1:0] mstatus_i,
   output logic            w_mepc,
   output logic [XLEN-1:0] mepc_v,
   output logic            w_mcause,
   output logic [XLEN-1:0] mcause_v,
   output logic            w_mstatus,
   output logic [XLEN-1:0] mstatus_v,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            trap_ack,
   output logic            mret_ack,
   output logic            busy
);
   import csr_trap_ctrl_pkg::*;

   localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, (XLEN-1)'(CAUSE_MTI[62:0])};

   state_t          state;
   state_t          state_nxt;
   logic [XLEN-1:0] epc_q;
   logic [XLEN-1:0] cause_q;
   logic [XLEN-1:0] status_q;
   logic            is_irq_q;

   logic            irq_pend;
   logic            accept_trap;
   logic            accept_irq;
   logic            accept_mret;
   logic [XLEN-1:0] trap_status;
   logic [XLEN-1:0] mret_status;
   logic [XLEN-1:0] trap_target;

   // Fixed priority among requests, only sampled while idle; losers simply keep their level up
   assign irq_pend    = irq_timer & irq_en & mstatus_i[MSTATUS_MIE];
   assign accept_trap = (state == ST_IDLE) & trap_req;
   assign accept_irq  = (state == ST_IDLE) & ~trap_req & irq_pend;
   assign accept_mret = (state == ST_IDLE) & ~trap_req & ~irq_pend & mret_req;

   csr_trap_target #(
      .XLEN      (XLEN),
      .VECTOR_EN (VECTOR_EN)
   ) u_target (
      .mtvec       (mtvec_i),
      .cause       (cause_q[5:0]),
      .is_irq      (is_irq_q),
      .redirect_pc (trap_target)
   );

   // State register; reset aborts any sequence in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Snapshot the trap context at acceptance so mid-sequence input changes do not matter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         epc_q    <= '0;
         cause_q  <= '0;
         status_q <= '0;
         is_irq_q <= 1'b0;
      end else if (accept_trap || accept_irq) begin
         epc_q    <= accept_trap ? trap_pc : irq_pc;
         cause_q  <= accept_trap ? trap_cause : IRQ_CAUSE;
         status_q <= mstatus_i;
         is_irq_q <= accept_irq;
      end else if (accept_mret) begin
         status_q <= mstatus_i;
         is_irq_q <= 1'b0;
      end
   end

   // Next-state: every non-idle state advances unconditionally after one cycle
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept_trap || accept_irq) begin
               state_nxt = ST_T_EPC;
            end else if (accept_mret) begin
               state_nxt = ST_R_STATUS;
            end
         end
         ST_T_EPC:    state_nxt = ST_T_CAUSE;
         ST_T_CAUSE:  state_nxt = ST_T_STATUS;
         ST_T_STATUS: state_nxt = ST_T_JUMP;
         ST_T_JUMP:   state_nxt = ST_IDLE;
         ST_R_STATUS: state_nxt = ST_R_JUMP;
         ST_R_JUMP:   state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // New mstatus images: trap stacks MIE into MPIE, mret restores it; both force MPP to machine
   always_comb begin
      trap_status                                 = status_q;
      trap_status[MSTATUS_MPIE]                   = status_q[MSTATUS_MIE];
      trap_status[MSTATUS_MIE]                    = 1'b0;
      trap_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = MPP_MACHINE;
      mret_status                                 = status_q;
      mret_status[MSTATUS_MIE]                    = status_q[MSTATUS_MPIE];
      mret_status[MSTATUS_MPIE]                   = 1'b1;
      mret_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = MPP_MACHINE;
   end

   // Outputs decode purely from state, so reset clears them without waiting for a clock
   always_comb begin
      w_mepc         = 1'b0;
      mepc_v         = '0;
      w_mcause       = 1'b0;
      mcause_v       = '0;
      w_mstatus      = 1'b0;
      mstatus_v      = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      trap_ack       = 1'b0;
      mret_ack       = 1'b0;
      busy           = (state != ST_IDLE);
      case (state)
         ST_T_EPC: begin
            w_mepc = 1'b1;
            mepc_v = epc_q;
         end
         ST_T_CAUSE: begin
            w_mcause = 1'b1;
            mcause_v = cause_q;
         end
         ST_T_STATUS: begin
            w_mstatus = 1'b1;
            mstatus_v = trap_status;
         end
         ST_T_JUMP: begin
            redirect_valid = 1'b1;
            redirect_pc    = trap_target;
            trap_ack       = 1'b1;
         end
         ST_R_STATUS: begin
            w_mstatus = 1'b1;
            mstatus_v = mret_status;
         end
         ST_R_JUMP: begin
            redirect_valid = 1'b1;
            redirect_pc    = mepc_i;
            mret_ack       = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb/tb_csr_trap_ctrl.sv - scoreboard bench for csr_trap_ctrl
module tb_csr_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        trap_req = 1'b0;
   logic [63:0] trap_cause = '0;
   logic [63:0] trap_pc = '0;
   logic        irq_timer = 1'b0;
   logic        irq_en = 1'b0;
   logic [63:0] irq_pc = '0;
   logic        mret_req = 1'b0;
   logic [63:0] mtvec_i = '0;
   logic [63:0] mepc_i = '0;
   logic [63:0] mstatus_i = '0;
   logic        w_mepc, w_mcause, w_mstatus, redirect_valid, trap_ack, mret_ack, busy;
   logic [63:0] mepc_v, mcause_v, mstatus_v, redirect_pc;

   csr_trap_ctrl #(.XLEN(64), .VECTOR_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
      .irq_timer(irq_timer), .irq_en(irq_en), .irq_pc(irq_pc),
      .mret_req(mret_req), .mtvec_i(mtvec_i), .mepc_i(mepc_i), .mstatus_i(mstatus_i),
      .w_mepc(w_mepc), .mepc_v(mepc_v), .w_mcause(w_mcause), .mcause_v(mcause_v),
      .w_mstatus(w_mstatus), .mstatus_v(mstatus_v),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .trap_ack(trap_ack), .mret_ack(mret_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   // event kinds: 0 mepc write, 1 mcause write, 2 mstatus write, 3 trap jump, 4 mret jump
   typedef struct {
      int          kind;
      int          cyc;
      logic [63:0] val;
   } exp_t;

   exp_t        q[$];
   int          n_asserts = 0;
   int          n_fail = 0;
   int          cyc = 0;
   bit          mon_en = 1'b0;
   int          m_kind;
   logic [63:0] m_val;
   exp_t        m_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int kind, input int c, input logic [63:0] v);
      exp_t e;
      e.kind = kind;
      e.cyc  = c;
      e.val  = v;
      q.push_back(e);
   endtask

   task automatic wait_ack(input bit want_mret);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (want_mret ? mret_ack : trap_ack) begin
            ok = 1'b1;
            break;
         end
      end
      chk(want_mret ? "mret_ack_seen" : "trap_ack_seen", ok, 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctrl"}, {busy, w_mepc, w_mcause, w_mstatus, redirect_valid, trap_ack, mret_ack}, 0);
      chk({tag, "_vals"}, mepc_v | mcause_v | mstatus_v | redirect_pc, 0);
   endtask

   // Monitor: every observed CSR write or redirect must match the next scoreboard entry
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         m_kind = -1;
         m_val  = '0;
         chk("one_event_max", ($countones({w_mepc, w_mcause, w_mstatus, redirect_valid}) <= 1), 1);
         if (w_mepc) begin
            m_kind = 0; m_val = mepc_v;
         end else if (w_mcause) begin
            m_kind = 1; m_val = mcause_v;
         end else if (w_mstatus) begin
            m_kind = 2; m_val = mstatus_v;
         end else if (redirect_valid) begin
            m_val = redirect_pc;
            if (trap_ack && !mret_ack) m_kind = 3;
            else if (mret_ack && !trap_ack) m_kind = 4;
            else m_kind = 9;
         end else if (trap_ack || mret_ack) begin
            m_kind = 8;
         end
         if (m_kind != -1) begin
            chk("busy_in_event", busy, 1);
            if (q.size() == 0) begin
               chk("unexpected_event", m_kind, -1);
            end else begin
               m_e = q.pop_front();
               chk($sformatf("kind_c%0d", m_e.cyc), m_kind, m_e.kind);
               chk($sformatf("cycle_k%0d", m_e.kind), cyc, m_e.cyc);
               chk($sformatf("value_k%0d_c%0d", m_e.kind, m_e.cyc), m_val, m_e.val);
            end
         end
      end
   end

   initial begin
      int c0;
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_after_reset", busy, 0);

      // ecall, direct mtvec
      c0 = cyc;
      trap_req = 1'b1; trap_cause = 64'd11; trap_pc = 64'h8000_0010;
      mtvec_i = 64'h8000_1000; mstatus_i = 64'h8;
      push(0, c0 + 1, 64'h8000_0010);
      push(1, c0 + 2, 64'd11);
      push(2, c0 + 3, 64'h1880);
      push(3, c0 + 4, 64'h8000_1000);
      wait_ack(1'b0);
      trap_req = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_after_ecall", busy, 0);

      // vectored timer interrupt
      c0 = cyc;
      irq_timer = 1'b1; irq_en = 1'b1; irq_pc = 64'h8000_0020;
      mtvec_i = 64'h8000_1001; mstatus_i = 64'h8;
      push(0, c0 + 1, 64'h8000_0020);
      push(1, c0 + 2, 64'h8000_0000_0000_0007);
      push(2, c0 + 3, 64'h1880);
      push(3, c0 + 4, 64'h8000_101C);
      wait_ack(1'b0);
      irq_timer = 1'b0;
      @(posedge clk);
      #1;

      // exception under vectored mtvec still goes to base
      c0 = cyc;
      trap_req = 1'b1; trap_cause = 64'd11; trap_pc = 64'h8000_0100;
      mtvec_i = 64'h8000_1001; mstatus_i = 64'h0;
      push(0, c0 + 1, 64'h8000_0100);
      push(1, c0 + 2, 64'd11);
      push(2, c0 + 3, 64'h1800);
      push(3, c0 + 4, 64'h8000_1000);
      wait_ack(1'b0);
      trap_req = 1'b0;
      @(posedge clk);
      #1;

      // interrupt with reserved mtvec mode is direct; high mstatus bits preserved
      c0 = cyc;
      irq_timer = 1'b1; irq_pc = 64'h8000_0040;
      mtvec_i = 64'h8000_2003; mstatus_i = 64'hA000_0000_0000_0008;
      push(0, c0 + 1, 64'h8000_0040);
      push(1, c0 + 2, 64'h8000_0000_0000_0007);
      push(2, c0 + 3, 64'hA000_0000_0000_1880);
      push(3, c0 + 4, 64'h8000_2000);
      wait_ack(1'b0);
      irq_timer = 1'b0;
      @(posedge clk);
      #1;

      // vector offset wraps around the top of the address space
      c0 = cyc;
      irq_timer = 1'b1; irq_pc = 64'h1234;
      mtvec_i = 64'hFFFF_FFFF_FFFF_FFF1; mstatus_i = 64'h8;
      push(0, c0 + 1, 64'h1234);
      push(1, c0 + 2, 64'h8000_0000_0000_0007);
      push(2, c0 + 3, 64'h1880);
      push(3, c0 + 4, 64'h0000_0000_0000_000C);
      wait_ack(1'b0);
      irq_timer = 1'b0;
      @(posedge clk);
      #1;

      // masked interrupts: global MIE clear, then MTIE clear
      irq_timer = 1'b1; irq_en = 1'b1; mstatus_i = 64'h0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("masked_busy_%0d", i), busy, 0);
      end
      irq_en = 1'b0; mstatus_i = 64'h8;
      repeat (5) @(posedge clk);
      #1;
      chk("mtie_masked_busy", busy, 0);
      irq_timer = 1'b0;

      // mret
      c0 = cyc;
      mret_req = 1'b1; mstatus_i = 64'h1880; mepc_i = 64'h8000_0014;
      push(2, c0 + 1, 64'h1888);
      push(4, c0 + 2, 64'h8000_0014);
      wait_ack(1'b1);
      mret_req = 1'b0;
      @(posedge clk);
      #1;

      // trap and mret together: trap first, mret right after idle
      c0 = cyc;
      trap_req = 1'b1; mret_req = 1'b1; trap_cause = 64'd2; trap_pc = 64'h8000_0200;
      mtvec_i = 64'h8000_1000; mstatus_i = 64'h8; mepc_i = 64'h8000_0300;
      push(0, c0 + 1, 64'h8000_0200);
      push(1, c0 + 2, 64'd2);
      push(2, c0 + 3, 64'h1880);
      push(3, c0 + 4, 64'h8000_1000);
      push(2, c0 + 6, 64'h1880);
      push(4, c0 + 7, 64'h8000_0300);
      wait_ack(1'b0);
      trap_req = 1'b0;
      wait_ack(1'b1);
      mret_req = 1'b0;
      @(posedge clk);
      #1;

      // reset while in T_CAUSE
      c0 = cyc;
      trap_req = 1'b1; trap_cause = 64'd11; trap_pc = 64'h8000_0400;
      push(0, c0 + 1, 64'h8000_0400);
      repeat (2) @(posedge clk);
      #1;
      chk("in_t_cause", w_mcause, 1);
      rst = 1'b1;
      trap_req = 1'b0;
      #1;
      chk_all_zero("async_reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("idle_after_abort", busy, 0);

      chk("scoreboard_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
